sonata_pinmux: RTL and testbench
================================

SONATA_PINMUX -- requirements
Module: sonata_pinmux

Interface
REQ-001 The block SHALL take parameter NumPins, default 80, the number of bidirectional pad-side pins.
REQ-002 The block SHALL take parameter NumBlkOut, default 32, the number of peripheral output signals offered to pins.
REQ-003 The block SHALL take parameter NumBlkIn, default 16, the number of peripheral input signals fed from pins.
REQ-004 The block SHALL take parameter FiltW, default 4, the glitch-filter counter width in bits.
REQ-005 Ports (name  direction  width  meaning):
- clk_i  in  1  the only clock.
- rst_ni  in  1  asynchronous active-low reset.
- reg_req_i  in  1  register access request.
- reg_we_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  10  word address.
- reg_wdata_i  in  32  write data.
- reg_rvalid_o  out  1  access complete.
- reg_rdata_o  out  32  read data.
- blk_out_i  in  NumBlkOut  peripheral output values.
- blk_oe_i  in  NumBlkOut  peripheral output enables.
- blk_in_o  out  NumBlkIn  filtered values to peripherals.
- pin_i  in  NumPins  raw pad input values.
- pin_o  out  NumPins  pad output values.
- pin_oe_o  out  NumPins  pad output enables.

Function
REQ-006 The block SHALL hold one 8-bit output-select register OSEL[p] per pin, at address p; 0 = pin undriven, k = blk_out_i[k-1].
REQ-007 The block SHALL hold one input-select register ISEL[j] per block input, at address 0x100+j; bits[7:0]: 0 = constant 0, k = pin k-1; bit 8 = filter enable.
REQ-008 The block SHALL hold a filter threshold register THR[FiltW-1:0] at address 0x200.
REQ-009 A write of a select value greater than its range (NumBlkOut for OSEL, NumPins for ISEL) SHALL store 0.
REQ-010 Writes to unmapped addresses SHALL be ignored.
REQ-011 Reads of unmapped addresses SHALL return 0.
REQ-012 Unused register bits SHALL read as 0.
REQ-013 Every access SHALL complete with reg_rvalid_o high exactly one cycle after reg_req_i.
REQ-014 reg_rdata_o SHALL be valid in that cycle and 0 in all other cycles.
REQ-015 Back-to-back requests SHALL be accepted every cycle.
REQ-016 pin_o[p] and pin_oe_o[p] SHALL be combinational from OSEL[p], blk_out_i and blk_oe_i.
REQ-017 With OSEL[p] = 0, pin_o[p] and pin_oe_o[p] SHALL both be 0.
REQ-018 A new OSEL value SHALL take effect in the cycle after the write.
REQ-019 Each pin_i bit SHALL pass through a 2-flop synchroniser before input selection.
REQ-020 With the filter disabled, blk_in_o[j] SHALL be registered from the selected synchronised pin: 3 cycles pin-to-output.
REQ-021 With the filter enabled, each block input SHALL keep counter CNT[j] and state F[j].
- If the selected sync value equals F[j], CNT SHALL clear to 0.
- Otherwise CNT SHALL increment.
- When CNT = THR and the value still differs, F SHALL take the new value and CNT SHALL clear.
- blk_in_o[j] = F[j].
REQ-022 With THR = 0, the filtered path SHALL behave as the unfiltered path.
REQ-023 CNT SHALL saturate and never wrap.
REQ-024 A write to ISEL[j] SHALL clear CNT[j] in the same cycle it updates.
REQ-025 F[j] SHALL be loaded directly from the newly selected source, unfiltered, in the cycle after that write.
REQ-026 A write to ISEL[j] that coincides with a pending filter update SHALL take priority over that update.

Reset
REQ-027 On rst_ni low, asynchronously, all OSEL, ISEL, THR, CNT, F, synchroniser flops, reg_rvalid_o and reg_rdata_o SHALL go to 0.
REQ-028 After reset, all pin_oe_o and blk_in_o SHALL be 0.
REQ-029 Reset asserted mid-access SHALL abort the access; no rvalid SHALL follow deassertion.
REQ-030 Release SHALL be synchronous to clk_i via the system reset synchroniser.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset, read 0x000, 0x100, 0x200 -> rvalid 1 cycle later, rdata 0; pin_oe_o all 0.
- Write OSEL[5]=3, blk_out_i[2]=1, blk_oe_i[2]=1 -> next cycle pin_o[5]=1, pin_oe_o[5]=1; write OSEL[5]=200 -> reads back 0, pin_oe_o[5]=0.
- ISEL[0]=0x001, pin_i[0] rises -> blk_in_o[0] rises exactly 3 cycles later.
- ISEL[1]=0x102, THR=3, pin_i[1] pulse 2 cycles -> blk_in_o[1] stays 0; 6-cycle pulse -> blk_in_o[1] rises 6 cycles after the edge.
- Filter counting, rewrite ISEL[1] to a pin held 1 -> CNT cleared, blk_in_o[1]=1 two cycles after the write (sync latency applies).
- rst_ni low during a write request -> register unchanged, no rvalid after release.

Source files
------------

// File: rtl/sonata_pinmux.sv
// sonata_pinmux: register-programmed pin multiplexer.
//
// Each pad output picks one peripheral output (OSEL); each peripheral input
// picks one synchronised pad input (ISEL), optionally through a glitch filter
// sharing one threshold register (THR).
//
// Register map (word addresses):
//   0x000 + p : OSEL[p]  [7:0]  0 = undriven, k = blk_out_i[k-1]
//   0x100 + j : ISEL[j]  [7:0]  0 = constant 0, k = pin k-1; [8] filter enable
//   0x200     : THR      [FiltW-1:0]
// Out-of-range select values store 0; unmapped writes are dropped and
// unmapped reads return 0.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   reg_*                  single-cycle register port, response one cycle later
//   blk_out_i / blk_oe_i   peripheral output values / enables
//   blk_in_o               filtered values to peripherals
//   pin_i                  raw pad inputs (asynchronous)
//   pin_o / pin_oe_o       pad outputs / output enables (combinational)
//
// rst_ni is expected to come from the system reset synchroniser, so its
// release is already aligned to clk_i.

// Per-pin output mux: one-hot decode of OSEL against the peripheral outputs.
module sonata_pinmux_out #(
  parameter int unsigned NumBlkOut = 32
) (
  input  logic [7:0]           osel_i,
  input  logic [NumBlkOut-1:0] blk_out_i,
  input  logic [NumBlkOut-1:0] blk_oe_i,
  output logic                 pin_o,
  output logic                 pin_oe_o
);
  logic [NumBlkOut-1:0] hit;

  for (genvar k = 0; k < NumBlkOut; k++) begin : g_hit
    assign hit[k] = (osel_i == 8'(k + 1));
  end

  // OSEL = 0 matches nothing, so the pin is left undriven and low.
  assign pin_o    = |(hit & blk_out_i);
  assign pin_oe_o = |(hit & blk_oe_i);
endmodule

// Per-block-input lane: source select plus glitch filter.
module sonata_pinmux_filt #(
  parameter int unsigned NumPins = 80,
  parameter int unsigned FiltW   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumPins-1:0] pins_i,     // synchronised pad inputs
  input  logic [8:0]         isel_i,
  input  logic [FiltW-1:0]   thr_i,
  input  logic               isel_wr_i,  // ISEL of this lane written this cycle
  output logic               val_o
);
  localparam logic [FiltW-1:0] CntMax = '1;

  logic [NumPins-1:0] hit;
  logic               src;
  logic               ld_q;
  logic [FiltW-1:0]   cnt_q;

  for (genvar k = 0; k < NumPins; k++) begin : g_hit
    assign hit[k] = (isel_i[7:0] == 8'(k + 1));
  end
  assign src = |(hit & pins_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_q  <= 1'b0;
      cnt_q <= '0;
      val_o <= 1'b0;
    end else begin
      ld_q <= isel_wr_i;
      if (isel_wr_i) begin
        // Select is changing: drop any count and any pending update.
        cnt_q <= '0;
      end else if (ld_q || !isel_i[8]) begin
        // First cycle on a new source, or filter off: follow source directly.
        val_o <= src;
        cnt_q <= '0;
      end else if (src == val_o) begin
        cnt_q <= '0;
      end else if (cnt_q >= thr_i) begin
        // >= rather than == so a threshold lowered mid-count cannot strand
        // a counter above it.
        val_o <= src;
        cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + FiltW'(1);
      end
    end
  end
endmodule

module sonata_pinmux #(
  parameter int unsigned NumPins   = 80,
  parameter int unsigned NumBlkOut = 32,
  parameter int unsigned NumBlkIn  = 16,
  parameter int unsigned FiltW     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 reg_req_i,
  input  logic                 reg_we_i,
  input  logic [9:0]           reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  output logic                 reg_rvalid_o,
  output logic [31:0]          reg_rdata_o,
  input  logic [NumBlkOut-1:0] blk_out_i,
  input  logic [NumBlkOut-1:0] blk_oe_i,
  output logic [NumBlkIn-1:0]  blk_in_o,
  input  logic [NumPins-1:0]   pin_i,
  output logic [NumPins-1:0]   pin_o,
  output logic [NumPins-1:0]   pin_oe_o
);
  logic [NumPins-1:0][7:0]  osel_q;
  logic [NumBlkIn-1:0][8:0] isel_q;
  logic [FiltW-1:0]         thr_q;
  logic [NumPins-1:0]       sync1_q, sync2_q;
  logic [NumBlkIn-1:0]      isel_wr;
  logic                     wr;
  logic [7:0]               osel_wval, isel_sval;
  logic [31:0]              rd_mux;
  logic                     unused_wdata;

  assign wr           = reg_req_i & reg_we_i;
  assign unused_wdata = ^reg_wdata_i[31:9];

  // Out-of-range selects collapse to 0 (undriven / constant 0).
  assign osel_wval = (reg_wdata_i[7:0] > 8'(NumBlkOut)) ? 8'h00 : reg_wdata_i[7:0];
  assign isel_sval = (reg_wdata_i[7:0] > 8'(NumPins))   ? 8'h00 : reg_wdata_i[7:0];

  for (genvar p = 0; p < NumPins; p++) begin : g_pin
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                              osel_q[p] <= '0;
      else if (wr && reg_addr_i == 10'(p))      osel_q[p] <= osel_wval;
    end

    sonata_pinmux_out #(.NumBlkOut(NumBlkOut)) u_out (
      .osel_i   (osel_q[p]),
      .blk_out_i(blk_out_i),
      .blk_oe_i (blk_oe_i),
      .pin_o    (pin_o[p]),
      .pin_oe_o (pin_oe_o[p])
    );
  end

  for (genvar j = 0; j < NumBlkIn; j++) begin : g_in
    assign isel_wr[j] = wr && (reg_addr_i == 10'(256 + j));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)         isel_q[j] <= '0;
      else if (isel_wr[j]) isel_q[j] <= {reg_wdata_i[8], isel_sval};
    end

    sonata_pinmux_filt #(.NumPins(NumPins), .FiltW(FiltW)) u_filt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .pins_i   (sync2_q),
      .isel_i   (isel_q[j]),
      .thr_i    (thr_q),
      .isel_wr_i(isel_wr[j]),
      .val_o    (blk_in_o[j])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      thr_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      if (wr && reg_addr_i == 10'h200) thr_q <= reg_wdata_i[FiltW-1:0];
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < NumPins; p++)
      if (reg_addr_i == 10'(p)) rd_mux = {24'h0, osel_q[p]};
    for (int j = 0; j < NumBlkIn; j++)
      if (reg_addr_i == 10'(256 + j)) rd_mux = {23'h0, isel_q[j]};
    if (reg_addr_i == 10'h200) rd_mux = 32'(thr_q);
  end

  // Response is registered; rdata is zero except in the cycle after a read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_rvalid_o <= 1'b0;
      reg_rdata_o  <= '0;
    end else begin
      reg_rvalid_o <= reg_req_i;
      reg_rdata_o  <= (reg_req_i && !reg_we_i) ? rd_mux : 32'h0;
    end
  end
endmodule

// File: tb/tb_sonata_pinmux.sv
module tb_sonata_pinmux;
  localparam int NP = 80, NO = 32, NI = 16, FW = 4;

  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          reg_req = 1'b0, reg_we = 1'b0;
  logic [9:0]    reg_addr = '0;
  logic [31:0]   reg_wdata = '0;
  logic          reg_rvalid;
  logic [31:0]   reg_rdata;
  logic [NO-1:0] blk_out = '0, blk_oe = '0;
  logic [NI-1:0] blk_in;
  logic [NP-1:0] pin_in = '0, pin_out, pin_oe;

  int n_checks = 0, n_err = 0;

  sonata_pinmux #(.NumPins(NP), .NumBlkOut(NO), .NumBlkIn(NI), .FiltW(FW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg_req_i(reg_req), .reg_we_i(reg_we), .reg_addr_i(reg_addr),
    .reg_wdata_i(reg_wdata), .reg_rvalid_o(reg_rvalid), .reg_rdata_o(reg_rdata),
    .blk_out_i(blk_out), .blk_oe_i(blk_oe), .blk_in_o(blk_in),
    .pin_i(pin_in), .pin_o(pin_out), .pin_oe_o(pin_oe)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One register access; returns at the negedge where the response is visible.
  task automatic reg_acc(input logic we, input logic [9:0] a, input logic [31:0] wd,
                         output logic [31:0] rd);
    @(negedge clk_i);
    reg_req = 1'b1; reg_we = we; reg_addr = a; reg_wdata = wd;
    @(negedge clk_i);
    reg_req = 1'b0; reg_we = 1'b0;
    check($sformatf("rvalid@%h", a), 128'(reg_rvalid), 128'(1));
    rd = reg_rdata;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; pin_in = '0; blk_out = '0; blk_oe = '0; reg_req = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[13];

  // Reference model state
  int            osel_m[NP];
  int            isel_m[NI];
  int            thr_m;
  int            cnt_m[NI];
  bit            f_m[NI];
  bit            wr_prev[NI];
  logic [NP-1:0] pin_hist1, pin_hist2;   // pad values sampled 1 and 2 edges ago
  bit            exp_rv;
  logic [31:0]   exp_rd;

  function automatic logic [31:0] model_read(input int a);
    if (a < NP)                  return 32'(osel_m[a]);
    if (a >= 256 && a < 256 + NI) return 32'(isel_m[a - 256]);
    if (a == 512)                return 32'(thr_m);
    return 32'h0;
  endfunction

  initial begin
    logic [31:0]   rd;
    logic [NP-1:0] e_pin, e_oe;
    logic [NI-1:0] e_in;
    int            a, s, src;

    tbl[0]  = '{10'h005, 32'd3,         32'd3};
    tbl[1]  = '{10'h005, 32'd200,       32'd0};
    tbl[2]  = '{10'h000, 32'd32,        32'd32};
    tbl[3]  = '{10'h001, 32'd33,        32'd0};
    tbl[4]  = '{10'h04F, 32'hFFFF_FF07, 32'd7};
    tbl[5]  = '{10'h050, 32'd5,         32'd0};
    tbl[6]  = '{10'h100, 32'h150,       32'h150};
    tbl[7]  = '{10'h101, 32'h151,       32'h100};
    tbl[8]  = '{10'h10F, 32'h1FF,       32'h100};
    tbl[9]  = '{10'h110, 32'd1,         32'd0};
    tbl[10] = '{10'h200, 32'hFFFF_FFF5, 32'd5};
    tbl[11] = '{10'h201, 32'd7,         32'd0};
    tbl[12] = '{10'h3FF, 32'd1,         32'd0};

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_rvalid", 128'(reg_rvalid), 128'(0));
    check("rst_rdata",  128'(reg_rdata),  128'(0));
    check("rst_pin_oe", 128'(pin_oe),     128'(0));
    check("rst_blk_in", 128'(blk_in),     128'(0));
    rst_ni = 1'b1;
    reg_acc(1'b0, 10'h000, 32'h0, rd); check("rd0_000", 128'(rd), 128'(0));
    reg_acc(1'b0, 10'h100, 32'h0, rd); check("rd0_100", 128'(rd), 128'(0));
    reg_acc(1'b0, 10'h200, 32'h0, rd); check("rd0_200", 128'(rd), 128'(0));
    @(negedge clk_i);
    check("idle_rvalid", 128'(reg_rvalid), 128'(0));
    check("idle_rdata",  128'(reg_rdata),  128'(0));

    // Register table: write, read back
    for (int i = 0; i < 13; i++) begin
      reg_acc(1'b1, tbl[i].addr, tbl[i].wdata, rd);
      reg_acc(1'b0, tbl[i].addr, 32'h0, rd);
      check($sformatf("tbl%0d_%h", i, tbl[i].addr), 128'(rd), 128'(tbl[i].exp));
    end

    // Output select
    do_reset();
    blk_out[2] = 1'b1; blk_oe[2] = 1'b1;
    @(negedge clk_i);
    check("oe5_before", 128'(pin_oe[5]), 128'(0));
    reg_acc(1'b1, 10'h005, 32'd3, rd);
    check("pin5_o",  128'(pin_out[5]), 128'(1));
    check("pin5_oe", 128'(pin_oe[5]),  128'(1));
    blk_oe[2] = 1'b0; #1;
    check("pin5_oe_comb", 128'(pin_oe[5]), 128'(0));
    blk_oe[2] = 1'b1;
    reg_acc(1'b1, 10'h005, 32'd200, rd);
    check("pin5_oe_clr", 128'(pin_oe[5]), 128'(0));
    reg_acc(1'b0, 10'h005, 32'h0, rd);
    check("osel5_rb", 128'(rd), 128'(0));

    // Unfiltered input: 3 cycles pin to output
    reg_acc(1'b1, 10'h100, 32'h001, rd);
    @(negedge clk_i);
    pin_in[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      check($sformatf("unflt_c%0d", k), 128'(blk_in[0]), 128'(k == 3));
    end

    // Filtered input, THR = 3
    pin_in[3] = 1'b1;
    reg_acc(1'b1, 10'h200, 32'd3, rd);
    reg_acc(1'b1, 10'h101, 32'h102, rd);
    // back-to-back reads
    @(negedge clk_i);
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = 10'h101;
    @(negedge clk_i);
    check("b2b0_rv", 128'(reg_rvalid), 128'(1));
    check("b2b0_rd", 128'(reg_rdata),  128'(32'h102));
    reg_addr = 10'h200;
    @(negedge clk_i);
    reg_req = 1'b0;
    check("b2b1_rv", 128'(reg_rvalid), 128'(1));
    check("b2b1_rd", 128'(reg_rdata),  128'(3));
    @(negedge clk_i);
    check("b2b2_rv", 128'(reg_rvalid), 128'(0));
    check("b2b2_rd", 128'(reg_rdata),  128'(0));

    pin_in[1] = 1'b1;
    repeat (2) @(negedge clk_i);
    pin_in[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      check($sformatf("glitch_c%0d", k), 128'(blk_in[1]), 128'(0));
    end
    pin_in[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_i);
      check($sformatf("pulse6_c%0d", k), 128'(blk_in[1]), 128'(k >= 6));
    end
    pin_in[1] = 1'b0;
    repeat (10) @(negedge clk_i);
    check("pulse6_fall", 128'(blk_in[1]), 128'(0));

    // Reselect while counting: load straight from the new source
    pin_in[1] = 1'b1;
    repeat (3) @(negedge clk_i);
    reg_acc(1'b1, 10'h101, 32'h104, rd);
    check("resel_w0", 128'(blk_in[1]), 128'(0));
    @(negedge clk_i);
    check("resel_w1", 128'(blk_in[1]), 128'(1));
    pin_in[1] = 1'b0;

    // Reset during a write request
    @(negedge clk_i);
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 10'h200; reg_wdata = 32'd9;
    #2 rst_ni = 1'b0;
    @(posedge clk_i); #1;
    reg_req = 1'b0; reg_we = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check($sformatf("abort_rv%0d", k), 128'(reg_rvalid), 128'(0));
    end
    reg_acc(1'b0, 10'h200, 32'h0, rd);
    check("abort_thr", 128'(rd), 128'(0));

    // Randomized run against the reference model
    do_reset();
    thr_m = 0; exp_rv = 0; exp_rd = '0; pin_hist1 = '0; pin_hist2 = '0;
    for (int p = 0; p < NP; p++) osel_m[p] = 0;
    for (int j = 0; j < NI; j++) begin
      isel_m[j] = 0; cnt_m[j] = 0; f_m[j] = 0; wr_prev[j] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        e_pin[p] = (osel_m[p] != 0) && blk_out[osel_m[p] - 1];
        e_oe[p]  = (osel_m[p] != 0) && blk_oe[osel_m[p] - 1];
      end
      for (int j = 0; j < NI; j++) e_in[j] = f_m[j];
      check("rnd_pin_o",  128'(pin_out),    128'(e_pin));
      check("rnd_pin_oe", 128'(pin_oe),     128'(e_oe));
      check("rnd_blk_in", 128'(blk_in),     128'(e_in));
      check("rnd_rvalid", 128'(reg_rvalid), 128'(exp_rv));
      check("rnd_rdata",  128'(reg_rdata),  128'(exp_rd));

      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 7) == 0) pin_in[p] = ~pin_in[p];
      blk_out = $urandom;
      blk_oe  = $urandom;
      reg_req = ($urandom_range(0, 2) == 0);
      reg_we  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          reg_addr  = 10'($urandom_range(0, NP - 1));
          reg_wdata = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 40));
        end
        3, 4, 5, 6: begin
          reg_addr  = 10'(256 + $urandom_range(0, NI - 1));
          reg_wdata = ($urandom & 32'hFFFF_FE00) | ($urandom_range(0, 1) << 8)
                      | 32'($urandom_range(0, 90));
        end
        7: begin
          reg_addr = 10'h200; reg_wdata = $urandom;
        end
        default: begin
          reg_addr  = 10'($urandom_range(NP, 255));
          if ($urandom_range(0, 1) == 1) reg_addr = 10'($urandom_range(256 + NI, 1023));
          if (reg_addr == 10'h200) reg_addr = 10'h201;
          reg_wdata = $urandom;
        end
      endcase

      // Model the coming clock edge from the values now being driven.
      a = int'(reg_addr);
      for (int j = 0; j < NI; j++) begin
        bit wr_j;
        wr_j = reg_req && reg_we && (a == 256 + j);
        s    = isel_m[j] % 256;
        src  = (s == 0) ? 0 : int'(pin_hist2[s - 1]);
        if (wr_j) cnt_m[j] = 0;
        else if (wr_prev[j] || isel_m[j] < 256) begin f_m[j] = 1'(src); cnt_m[j] = 0; end
        else if (src == int'(f_m[j])) cnt_m[j] = 0;
        else if (cnt_m[j] >= thr_m) begin f_m[j] = 1'(src); cnt_m[j] = 0; end
        else if (cnt_m[j] < (1 << FW) - 1) cnt_m[j]++;
        wr_prev[j] = wr_j;
      end
      exp_rv = reg_req;
      exp_rd = (reg_req && !reg_we) ? model_read(a) : 32'h0;
      if (reg_req && reg_we) begin
        s = int'(reg_wdata[7:0]);
        if (a < NP) osel_m[a] = (s > NO) ? 0 : s;
        else if (a >= 256 && a < 256 + NI)
          isel_m[a - 256] = (reg_wdata[8] ? 256 : 0) + ((s > NP) ? 0 : s);
        else if (a == 512) thr_m = int'(reg_wdata[FW-1:0]);
      end
      pin_hist2 = pin_hist1;
      pin_hist1 = pin_in;
      @(negedge clk_i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
